// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: entry layout, trigger levels
// and character-timeout scaling.
package uart_rx_fifo_pkg;

    localparam int unsigned ENTRY_WIDTH = 11;

    // Bit positions of the per-character flags inside a stored entry
    localparam int unsigned BIT_FRAME_ERROR  = 8;
    localparam int unsigned BIT_PARITY_ERROR = 9;
    localparam int unsigned BIT_BREAK        = 10;

    // Ticks of the 16x baud clock per frame bit, times four character times
    localparam int unsigned TIMEOUT_MULT  = 64;
    localparam int unsigned TIMEOUT_WIDTH = 10;

    typedef enum logic [1:0] {
        TRIG_1  = 2'd0,
        TRIG_4  = 2'd1,
        TRIG_8  = 2'd2,
        TRIG_14 = 2'd3
    } trigger_level_e;

    // Packed so that data sits in [7:0] and the flags in [10:8]
    typedef struct packed {
        logic       brk;
        logic       parity_error;
        logic       frame_error;
        logic [7:0] data;
    } rx_entry_t;

    function automatic int unsigned trigger_threshold(trigger_level_e lvl);
        int unsigned thr;
        unique case (lvl)
            TRIG_1:  thr = 1;
            TRIG_4:  thr = 4;
            TRIG_8:  thr = 8;
            TRIG_14: thr = 14;
            default: thr = 1;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side write port, bus-side FWFT read port and interrupt outputs of
// the receive FIFO. The master drives the FIFO inputs, the slave is the FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                fifo_clear;
    logic                baud_rate_x16_tick;
    logic [3:0]          frame_bits;
    logic [1:0]          trigger_level;
    logic [7:0]          rx_data;
    logic                rx_we;
    logic                rx_frame_error;
    logic                rx_parity_error;
    logic                rx_break;
    logic                fifo_full;
    logic                read_req;
    logic [7:0]          read_data;
    logic                read_frame_error;
    logic                read_parity_error;
    logic                read_break;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                data_available_irq;
    logic                timeout_irq;
    logic                error_in_fifo;

    modport master (
        output fifo_clear, baud_rate_x16_tick, frame_bits, trigger_level,
        output rx_data, rx_we, rx_frame_error, rx_parity_error, rx_break, read_req,
        input  fifo_full, read_data, read_frame_error, read_parity_error, read_break,
        input  fifo_empty, fifo_count, data_available_irq, timeout_irq, error_in_fifo
    );

    modport slave (
        input  fifo_clear, baud_rate_x16_tick, frame_bits, trigger_level,
        input  rx_data, rx_we, rx_frame_error, rx_parity_error, rx_break, read_req,
        output fifo_full, read_data, read_frame_error, read_parity_error, read_break,
        output fifo_empty, fifo_count, data_available_irq, timeout_irq, error_in_fifo
    );

endinterface

// File: rtl/uart_rx_timeout.sv
// Character-timeout detector: counts 16x baud ticks while the FIFO sits idle
// and non-empty, saturating at four character times.
module uart_rx_timeout
    import uart_rx_fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [3:0] frame_bits,
    input  logic       empty_next,
    output logic       timeout_irq
);

    logic [TIMEOUT_WIDTH-1:0] limit;
    logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
    logic                     irq_q;

    assign limit = TIMEOUT_WIDTH'(frame_bits) * TIMEOUT_WIDTH'(TIMEOUT_MULT);

    // Next counter value; a lowered frame_bits pulls the count back to the new limit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q > limit) begin
            count_d = limit;
        end else if (tick && (count_q < limit)) begin
            count_d = count_q + TIMEOUT_WIDTH'(1);
        end
    end

    // Counter and IRQ registers; IRQ follows the next count so it drops with the clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            irq_q   <= (count_d == limit) && !empty_next;
        end
    end

    assign timeout_irq = irq_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: 2^DEPTH_LOG2 entries of data plus error flags, FWFT read
// port, trigger-level, timeout and error-in-FIFO status.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input logic           clock,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    rx_entry_t             mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;
    logic                  data_avail_q;
    logic                  full, empty, empty_next;
    logic                  push, pop;
    logic                  wr_err, head_err, timer_clear;
    rx_entry_t             wr_entry, head;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign empty_next = (count_d == '0);

    // A write hitting a full FIFO freezes the whole cycle, coincident pop included
    assign push = bus.rx_we && !full;
    assign pop  = bus.read_req && !empty && !(bus.rx_we && full);

    assign wr_entry = '{
        brk:          bus.rx_break,
        parity_error: bus.rx_parity_error,
        frame_error:  bus.rx_frame_error,
        data:         bus.rx_data
    };
    assign head     = mem[rd_ptr_q];
    assign wr_err   = bus.rx_frame_error | bus.rx_parity_error | bus.rx_break;
    assign head_err = head.frame_error | head.parity_error | head.brk;

    assign timer_clear = bus.fifo_clear | push | pop | empty;

    // Next entry count and count of stored entries carrying any error flag
    always_comb begin
        count_d     = count_q;
        err_count_d = err_count_q;
        if (bus.fifo_clear) begin
            count_d     = '0;
            err_count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push && wr_err && !(pop && head_err)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end else if (pop && head_err && !(push && wr_err)) begin
                err_count_d = err_count_q - CNT_W'(1);
            end
        end
    end

    // Pointers, counters and the registered data-available interrupt
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_count_q  <= '0;
            data_avail_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            err_count_q  <= err_count_d;
            data_avail_q <= (count_d >=
                CNT_W'(trigger_threshold(trigger_level_e'(bus.trigger_level))));
            if (bus.fifo_clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clock) begin
        if (push && !bus.fifo_clear) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // FWFT head presentation, forced to zero while empty
    always_comb begin
        bus.read_data         = '0;
        bus.read_frame_error  = 1'b0;
        bus.read_parity_error = 1'b0;
        bus.read_break        = 1'b0;
        if (!empty) begin
            bus.read_data         = head.data;
            bus.read_frame_error  = head.frame_error;
            bus.read_parity_error = head.parity_error;
            bus.read_break        = head.brk;
        end
    end

    assign bus.fifo_full          = full;
    assign bus.fifo_empty         = empty;
    assign bus.fifo_count         = count_q;
    assign bus.data_available_irq = data_avail_q;
    assign bus.error_in_fifo      = (err_count_q != '0);

    uart_rx_timeout u_timeout (
        .clock       (clock),
        .reset       (reset),
        .clear       (timer_clear),
        .tick        (bus.baud_rate_x16_tick),
        .frame_bits  (bus.frame_bits),
        .empty_next  (empty_next),
        .timeout_irq (bus.timeout_irq)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model checked
// every cycle, a vector table, directed corner sequences and random traffic.
module tb_uart_rx_fifo;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus_if ();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {break, parity, frame, data}
    logic [10:0] mq[$];
    int          to_cnt = 0;
    logic        exp_da = 1'b0;
    logic        exp_to = 1'b0;
    int unsigned thr [4] = '{1, 4, 8, 14};

    typedef struct {
        logic       we;
        logic       req;
        logic       clr;
        logic [7:0] data;
        int         exp_count;
        logic [7:0] exp_data;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic req, input logic clr,
                         input logic [7:0] d, input logic [2:0] fl, input logic tk);
        bus_if.rx_we              = we;
        bus_if.read_req           = req;
        bus_if.fifo_clear         = clr;
        bus_if.rx_data            = d;
        bus_if.rx_frame_error     = fl[0];
        bus_if.rx_parity_error    = fl[1];
        bus_if.rx_break           = fl[2];
        bus_if.baud_rate_x16_tick = tk;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0);
    endtask

    task automatic model_reset();
        mq.delete();
        to_cnt = 0;
        exp_da = 1'b0;
        exp_to = 1'b0;
    endtask

    // Apply the behavioural rules for one clock edge using the inputs seen there
    task automatic model_edge();
        int lim;
        bit full, empty, push, pop;
        lim = 64 * int'(bus_if.frame_bits);
        if (bus_if.fifo_clear) begin
            mq.delete();
            to_cnt = 0;
        end else begin
            full  = (mq.size() == 16);
            empty = (mq.size() == 0);
            push  = bus_if.rx_we && !full;
            pop   = bus_if.read_req && !empty && !(bus_if.rx_we && full);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({bus_if.rx_break, bus_if.rx_parity_error,
                                    bus_if.rx_frame_error, bus_if.rx_data});
            if (push || pop || empty) to_cnt = 0;
            else if (to_cnt > lim) to_cnt = lim;
            else if (bus_if.baud_rate_x16_tick && to_cnt < lim) to_cnt++;
        end
        exp_da = (mq.size() >= int'(thr[bus_if.trigger_level]));
        exp_to = (to_cnt == lim) && (mq.size() != 0);
    endtask

    task automatic check_all();
        logic [10:0] h;
        logic        anyerr;
        h      = (mq.size() != 0) ? mq[0] : 11'h000;
        anyerr = 1'b0;
        foreach (mq[i]) if (mq[i][10:8] != 3'b000) anyerr = 1'b1;
        chk("count", 32'(bus_if.fifo_count), 32'(mq.size()));
        chk("empty", 32'(bus_if.fifo_empty), 32'(mq.size() == 0));
        chk("full", 32'(bus_if.fifo_full), 32'(mq.size() == 16));
        chk("read_data", 32'(bus_if.read_data), 32'(h[7:0]));
        chk("read_flags", 32'({bus_if.read_break, bus_if.read_parity_error,
                               bus_if.read_frame_error}), 32'(h[10:8]));
        chk("error_in_fifo", 32'(bus_if.error_in_fifo), 32'(anyerr));
        chk("data_avail_irq", 32'(bus_if.data_available_irq), 32'(exp_da));
        chk("timeout_irq", 32'(bus_if.timeout_irq), 32'(exp_to));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clear_fifo();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 3'b000, 1'b0);
        step();
        idle();
    endtask

    initial begin
        reset                = 1'b1;
        bus_if.frame_bits    = 4'd7;
        bus_if.trigger_level = 2'd0;
        idle();
        #12;
        check_all();
        @(negedge clock);
        reset = 1'b0;

        // Vector table: single write/read, simultaneous ops, empty-pop, clear priority
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h41, 1, 8'h41, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h10, 1, 8'h10, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h20, 2, 8'h10, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h30, 2, 8'h20, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h30, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h55, 1, 8'h55, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h66, 1, 8'h66, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h77, 0, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b1});
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].req, vecs[i].clr, vecs[i].data, 3'b000, 1'b0);
            step();
            chk($sformatf("vec%0d_count", i), 32'(bus_if.fifo_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_data", i), 32'(bus_if.read_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_empty", i), 32'(bus_if.fifo_empty), 32'(vecs[i].exp_empty));
        end
        idle();

        // Fill to 16, drop a 17th (also with a coincident pop), drain in order
        clear_fifo();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i), 3'b000, 1'b0);
            step();
        end
        chk("full_at_16", 32'(bus_if.fifo_full), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 3'b000, 1'b0);
        step();
        chk("drop_17th_count", 32'(bus_if.fifo_count), 32'd16);
        drive(1'b1, 1'b1, 1'b0, 8'hEE, 3'b000, 1'b0);
        step();
        chk("full_we_req_count", 32'(bus_if.fifo_count), 32'd16);
        chk("full_we_req_head", 32'(bus_if.read_data), 32'h00);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(bus_if.read_data), 32'(i));
            drive(1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0);
            step();
        end
        chk("drained_empty", 32'(bus_if.fifo_empty), 32'd1);

        // Second pass straddles the pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i), 3'b000, 1'b0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h28 + i), 3'b000, 1'b0);
            step();
        end
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("wrap_%0d", i), 32'(bus_if.read_data), 32'(8'h24 + i));
            drive(1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0);
            step();
        end
        idle();

        // Trigger level 8
        clear_fifo();
        bus_if.trigger_level = 2'd2;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h80 + i), 3'b000, 1'b0);
            step();
        end
        chk("trig8_at_7", 32'(bus_if.data_available_irq), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 8'h87, 3'b000, 1'b0);
        step();
        chk("trig8_at_8", 32'(bus_if.data_available_irq), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0);
        step();
        chk("trig8_pop", 32'(bus_if.data_available_irq), 32'd0);
        idle();
        bus_if.trigger_level = 2'd0;

        // Character timeout with frame_bits = 10: 640 ticks, cleared by pop then by write
        clear_fifo();
        bus_if.frame_bits = 4'd10;
        for (int pass = 0; pass < 2; pass++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h5A, 3'b000, 1'b0);
            step();
            for (int i = 1; i <= 640; i++) begin
                drive(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1);
                step();
                idle();
                step();
                if (i == 639) chk($sformatf("timeout_639_p%0d", pass),
                                  32'(bus_if.timeout_irq), 32'd0);
                if (i == 640) chk($sformatf("timeout_640_p%0d", pass),
                                  32'(bus_if.timeout_irq), 32'd1);
            end
            if (pass == 0) drive(1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0);
            else           drive(1'b1, 1'b0, 1'b0, 8'h5B, 3'b000, 1'b0);
            step();
            chk($sformatf("timeout_clear_p%0d", pass), 32'(bus_if.timeout_irq), 32'd0);
            idle();
        end
        bus_if.frame_bits = 4'd7;

        // Parity errors on entries 2 and 5
        clear_fifo();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h30 + k), (k == 2 || k == 5) ? 3'b010 : 3'b000, 1'b0);
            step();
        end
        chk("err_after_fill", 32'(bus_if.error_in_fifo), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0);
            step();
            chk($sformatf("err_after_pop%0d", k), 32'(bus_if.error_in_fifo), 32'(k < 5));
        end
        idle();

        // Asynchronous reset between clock edges, then clear beating a write
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h90 + i), 3'b100, 1'b0);
            step();
        end
        idle();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_count", 32'(bus_if.fifo_count), 32'd0);
        chk("async_rst_empty", 32'(bus_if.fifo_empty), 32'd1);
        chk("async_rst_err", 32'(bus_if.error_in_fifo), 32'd0);
        check_all();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), 3'b000, 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 8'hBB, 3'b000, 1'b0);
        step();
        chk("clear_with_we_empty", 32'(bus_if.fifo_empty), 32'd1);
        chk("clear_with_we_data", 32'(bus_if.read_data), 32'd0);
        idle();

        // Random traffic against the model, with biased fill/drain phases
        for (int blk = 0; blk < 12; blk++) begin
            int unsigned wp, rp;
            bus_if.trigger_level = 2'($urandom_range(0, 3));
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int c = 0; c < 250; c++) begin
                drive($urandom_range(0, 99) < wp,
                      $urandom_range(0, 99) < rp,
                      $urandom_range(0, 199) == 0,
                      8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                      1'($urandom_range(0, 1)));
                step();
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
